// File: rtl/float_div_pkg.sv
// Shared constants, operand classes and classifier helpers for the E8/M23
// reciprocal-multiply quotient stage.
package float_div_pkg;

    // Field widths
    localparam int E_W  = 8;
    localparam int M_W  = 23;
    localparam int XW   = 37;
    localparam int XE_W = 9;
    localparam int XM_W = 27;
    localparam int P_W  = 51;
    localparam int ES_W = 11;

    // Pipeline depth in enabled cycles
    localparam int LAT = 3;

    // Reciprocal word layout
    localparam int X_SIGN_BIT = 36;
    localparam int X_EXP_MSB  = 35;
    localparam int X_EXP_LSB  = 27;
    localparam int X_MAN_MSB  = 26;
    localparam int X_MAN_LSB  = 0;

    localparam logic [XE_W-1:0] X_EXP_SPECIAL = 9'h1FF;
    localparam logic [E_W-1:0]  B_EXP_SPECIAL = 8'hFF;
    localparam logic signed [ES_W-1:0] EXP_BIAS = 11'sd127;
    localparam logic [31:0]     QNAN          = 32'h7FC00000;

    // Flag bit positions within {invalid, div_by_zero, overflow, underflow, inexact}
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_FINITE = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } cls_e;

    // Dividend class; a zero exponent flushes subnormals to zero
    function automatic cls_e classify_b(input logic [E_W-1:0] exp_v, input logic [M_W-1:0] man_v);
        cls_e c;
        if (exp_v == 8'd0) begin
            c = CLS_ZERO;
        end else if (exp_v == B_EXP_SPECIAL) begin
            if (man_v == 23'd0) begin
                c = CLS_INF;
            end else begin
                c = CLS_NAN;
            end
        end else begin
            c = CLS_FINITE;
        end
        return c;
    endfunction

    // Reciprocal class; zero means a was infinite, infinite means a was zero
    function automatic cls_e classify_x(input logic [XE_W-1:0] exp_v, input logic [XM_W-1:0] man_v);
        cls_e c;
        if (exp_v == 9'd0) begin
            c = CLS_ZERO;
        end else if (exp_v == X_EXP_SPECIAL) begin
            if (man_v == 27'd0) begin
                c = CLS_INF;
            end else begin
                c = CLS_NAN;
            end
        end else begin
            c = CLS_FINITE;
        end
        return c;
    endfunction

endpackage

// File: rtl/float_div_rnd_e8_m23.sv
// Combinational normalize, round-to-nearest-even and range check for the
// 24x27-bit product of dividend and reciprocal mantissas.
module float_div_rnd_e8_m23
    import float_div_pkg::*;
(
    input  logic [P_W-1:0]         p,
    input  logic signed [ES_W-1:0] esum,
    input  logic                   sign,
    output logic [31:0]            q,
    output logic [4:0]             flags
);

    logic [M_W-1:0]         m_s;
    logic                   g_s;
    logic                   s_s;
    logic                   up_s;
    logic [M_W:0]           m_sum_s;
    logic signed [ES_W-1:0] e_norm_s;
    logic signed [ES_W-1:0] e_fin_s;

    // Pick the mantissa window from the product's leading bit (product lies in [1,4))
    always_comb begin
        m_s      = p[48:26];
        g_s      = p[25];
        s_s      = |p[24:0];
        e_norm_s = esum;
        if (p[50]) begin
            m_s      = p[49:27];
            g_s      = p[26];
            s_s      = |p[25:0];
            e_norm_s = esum + 11'sd1;
        end else begin
            m_s      = p[48:26];
            g_s      = p[25];
            s_s      = |p[24:0];
            e_norm_s = esum;
        end
    end

    // Round to nearest even; a mantissa carry-out bumps the exponent and leaves a zero fraction
    always_comb begin
        up_s    = g_s & (s_s | m_s[0]);
        m_sum_s = {1'b0, m_s} + {23'd0, up_s};
        e_fin_s = e_norm_s;
        if (m_sum_s[M_W]) begin
            e_fin_s = e_norm_s + 11'sd1;
        end else begin
            e_fin_s = e_norm_s;
        end
    end

    // Saturate to infinity or flush to zero outside the normal exponent range
    always_comb begin
        q     = 32'd0;
        flags = 5'd0;
        if (e_fin_s >= 11'sd255) begin
            q             = {sign, B_EXP_SPECIAL, 23'd0};
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else if (e_fin_s <= 11'sd0) begin
            q             = {sign, 31'd0};
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else begin
            q             = {sign, e_fin_s[E_W-1:0], m_sum_s[M_W-1:0]};
            flags[FLG_NX] = g_s | s_s;
        end
    end

endmodule

// File: rtl/float_div_rcp_mul_e8_m23_pipe.sv
// Three-stage stallable pipeline producing q = b * x, where x is the 37-bit
// reciprocal word of the divisor. Subnormals are flushed to zero.
module float_div_rcp_mul_e8_m23_pipe
    import float_div_pkg::*;
(
    input  logic            aclk,
    input  logic            arst_n,
    input  logic            astall,
    input  logic            in_vld,
    input  logic            b_sign,
    input  logic [E_W-1:0]  b_exp,
    input  logic [M_W-1:0]  b_man,
    input  logic [XW-1:0]   x,
    output logic            out_vld,
    output logic [31:0]     q,
    output logic [4:0]      q_flags
);

    logic                   en_s;
    logic [LAT-1:0]         vld_r;

    logic                   s1_sign_r;
    logic [E_W-1:0]         s1_b_exp_r;
    logic [M_W-1:0]         s1_b_man_r;
    logic [XE_W-1:0]        s1_x_exp_r;
    logic [XM_W-1:0]        s1_x_man_r;

    cls_e                   b_cls_s;
    cls_e                   x_cls_s;
    logic                   spec_s;
    logic [31:0]            spec_q_s;
    logic [4:0]             spec_flags_s;
    logic [P_W-1:0]         p_s;
    logic signed [ES_W-1:0] esum_s;

    logic                   s2_sign_r;
    logic                   s2_spec_r;
    logic [31:0]            s2_spec_q_r;
    logic [4:0]             s2_spec_flags_r;
    logic [P_W-1:0]         s2_p_r;
    logic signed [ES_W-1:0] s2_esum_r;

    logic [31:0]            rnd_q_s;
    logic [4:0]             rnd_flags_s;

    assign en_s    = ~astall;
    assign out_vld = vld_r[LAT-1];

    // Valid chain: one bit per stage, shifted only on enabled edges
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            vld_r <= {LAT{1'b0}};
        end else if (en_s) begin
            vld_r <= {vld_r[LAT-2:0], in_vld};
        end
    end

    // Stage 1: capture operands and the quotient sign
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            s1_sign_r  <= 1'b0;
            s1_b_exp_r <= 8'd0;
            s1_b_man_r <= 23'd0;
            s1_x_exp_r <= 9'd0;
            s1_x_man_r <= 27'd0;
        end else if (en_s) begin
            s1_sign_r  <= b_sign ^ x[X_SIGN_BIT];
            s1_b_exp_r <= b_exp;
            s1_b_man_r <= b_man;
            s1_x_exp_r <= x[X_EXP_MSB:X_EXP_LSB];
            s1_x_man_r <= x[X_MAN_MSB:X_MAN_LSB];
        end
    end

    // Classify operands and resolve special results in priority order
    always_comb begin
        b_cls_s      = classify_b(s1_b_exp_r, s1_b_man_r);
        x_cls_s      = classify_x(s1_x_exp_r, s1_x_man_r);
        spec_s       = 1'b0;
        spec_q_s     = 32'd0;
        spec_flags_s = 5'd0;
        if ((b_cls_s == CLS_NAN) || (x_cls_s == CLS_NAN) ||
            ((b_cls_s == CLS_INF) && (x_cls_s == CLS_ZERO)) ||
            ((b_cls_s == CLS_ZERO) && (x_cls_s == CLS_INF))) begin
            spec_s               = 1'b1;
            spec_q_s             = QNAN;
            spec_flags_s[FLG_NV] = 1'b1;
        end else if ((x_cls_s == CLS_INF) && (b_cls_s == CLS_FINITE)) begin
            spec_s               = 1'b1;
            spec_q_s             = {s1_sign_r, B_EXP_SPECIAL, 23'd0};
            spec_flags_s[FLG_DZ] = 1'b1;
        end else if (b_cls_s == CLS_INF) begin
            spec_s   = 1'b1;
            spec_q_s = {s1_sign_r, B_EXP_SPECIAL, 23'd0};
        end else if ((b_cls_s == CLS_ZERO) || (x_cls_s == CLS_ZERO)) begin
            spec_s   = 1'b1;
            spec_q_s = {s1_sign_r, 31'd0};
        end else begin
            spec_s       = 1'b0;
            spec_q_s     = 32'd0;
            spec_flags_s = 5'd0;
        end
    end

    // Mantissa product (1.23 x 1.26 -> 2.49) and unbiased exponent sum
    always_comb begin
        p_s    = {27'd0, 1'b1, s1_b_man_r} * {24'd0, s1_x_man_r};
        esum_s = $signed({3'b000, s1_b_exp_r}) + $signed({2'b00, s1_x_exp_r}) - EXP_BIAS;
    end

    // Stage 2: register product, exponent sum and any special-case result
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            s2_sign_r       <= 1'b0;
            s2_spec_r       <= 1'b0;
            s2_spec_q_r     <= 32'd0;
            s2_spec_flags_r <= 5'd0;
            s2_p_r          <= {P_W{1'b0}};
            s2_esum_r       <= 11'sd0;
        end else if (en_s) begin
            s2_sign_r       <= s1_sign_r;
            s2_spec_r       <= spec_s;
            s2_spec_q_r     <= spec_q_s;
            s2_spec_flags_r <= spec_flags_s;
            s2_p_r          <= p_s;
            s2_esum_r       <= esum_s;
        end
    end

    float_div_rnd_e8_m23 u_rnd (
        .p     (s2_p_r),
        .esum  (s2_esum_r),
        .sign  (s2_sign_r),
        .q     (rnd_q_s),
        .flags (rnd_flags_s)
    );

    // Stage 3: registered result, special cases bypass the rounder
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            q       <= 32'd0;
            q_flags <= 5'd0;
        end else if (en_s) begin
            if (s2_spec_r) begin
                q       <= s2_spec_q_r;
                q_flags <= s2_spec_flags_r;
            end else begin
                q       <= rnd_q_s;
                q_flags <= rnd_flags_s;
            end
        end
    end

endmodule
